// File: rtl/parking_pkg.sv
// Shared types and constants for the parking lot gate controllers.
package parking_pkg;
    localparam int CODE_W = 4;
    localparam logic [CODE_W-1:0] EXIT_CODE_DEF = 4'b1001;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICKET,
        CHECK,
        OPEN,
        PASSING,
        DENY
    } exit_state_e;
endpackage

// File: rtl/parking_tick_gen.sv
// Human-scale tick prescaler: one-cycle tick every TICK_DIV clk cycles, restartable.
module parking_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/parking_exit_gate.sv
// Exit gate controller: ticket check, timeout/deny, barrier, LEDs and lot occupancy.
// Optional PARKING_EXIT_OVERRIDE_EN adds the attendant_open override input.
module parking_exit_gate
    import parking_pkg::*;
#(
    parameter int                TICK_DIV      = 25_000_000,
    parameter int                TIMEOUT_TICKS = 30,
    parameter int                DENY_TICKS    = 8,
    parameter int                CAPACITY      = 16,
    parameter int                CNT_W         = 5,
    parameter logic [CODE_W-1:0] EXIT_CODE     = EXIT_CODE_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              car_entered,
    input  logic              sensor_exit_in,
    input  logic              sensor_exit_out,
    input  logic              ticket_valid,
    input  logic [CODE_W-1:0] ticket_code,
`ifdef PARKING_EXIT_OVERRIDE_EN
    input  logic              attendant_open,
`endif
    output logic              ticket_ready,
    output logic              gate_open,
    output logic              GREEN_LED,
    output logic              RED_LED,
    output logic [CNT_W-1:0]  occupancy,
    output logic              lot_full,
    output logic              lot_empty,
    output logic              err_underflow
);
    localparam int TMAX = (TIMEOUT_TICKS > DENY_TICKS) ? TIMEOUT_TICKS : DENY_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    exit_state_e       state_q, state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              gate_q, gate_d, green_q, green_d, red_q, red_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              err_q, err_d;
    logic              tick, restart, accept, exit_done;

    // The prescaler phase realigns on every state change so timeouts count from entry.
    assign restart = (state_d != state_q);

    parking_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .tick    (tick)
    );

    assign ticket_ready = (state_q == WAIT_TICKET);
    assign accept       = ticket_valid && ticket_ready;
    assign exit_done    = (state_q == PASSING) && !sensor_exit_out;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        code_d  = code_q;
        red_d   = red_q;
        case (state_q)
            IDLE:        if (sensor_exit_in) state_d = WAIT_TICKET;
            WAIT_TICKET: begin
                if (accept) begin
                    code_d  = ticket_code;
                    state_d = CHECK;
                end else if (tick && tcnt_q == TW'(TIMEOUT_TICKS - 1)) begin
                    state_d = DENY;
                end else if (!sensor_exit_in) begin
                    state_d = IDLE;
                end else if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            CHECK:       state_d = (code_q == EXIT_CODE) ? OPEN : DENY;
            OPEN:        if (sensor_exit_out) state_d = PASSING;
            PASSING:     if (!sensor_exit_out) state_d = IDLE;
            DENY: begin
                if (tick) begin
                    if (tcnt_q == TW'(DENY_TICKS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                        red_d  = ~red_q;
                    end
                end
            end
            default:     state_d = IDLE;
        endcase
`ifdef PARKING_EXIT_OVERRIDE_EN
        if (attendant_open && (state_q == WAIT_TICKET || state_q == DENY)) state_d = OPEN;
`endif
        if (state_d != state_q) tcnt_d = '0;

        gate_d  = (state_d == OPEN) || (state_d == PASSING);
        green_d = gate_d;
        if (state_d == WAIT_TICKET || (state_d == DENY && state_q != DENY)) red_d = 1'b1;
        else if (state_d != DENY)                                          red_d = 1'b0;
    end

    // Entry and exit in the same cycle cancel, including at zero.
    always_comb begin
        occ_d = occ_q;
        err_d = err_q;
        case ({car_entered, exit_done})
            2'b10: if (occ_q != CNT_W'(CAPACITY)) occ_d = occ_q + 1'b1;
            2'b01: begin
                if (occ_q == '0) err_d = 1'b1;
                else             occ_d = occ_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            code_q  <= '0;
            gate_q  <= 1'b0;
            green_q <= 1'b0;
            red_q   <= 1'b0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            code_q  <= code_d;
            gate_q  <= gate_d;
            green_q <= green_d;
            red_q   <= red_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end

    assign gate_open     = gate_q;
    assign GREEN_LED     = green_q;
    assign RED_LED       = red_q;
    assign occupancy     = occ_q;
    assign err_underflow = err_q;
    assign lot_full      = (occ_q == CNT_W'(CAPACITY));
    assign lot_empty     = (occ_q == '0);
endmodule

// File: tb/tb_parking_exit_gate.sv
// Bench for parking_exit_gate: cycle-count model of the exit flow checked every cycle,
// plus directed scenarios with literal expectations.
module tb_parking_exit_gate;
    localparam int DIV = 4, TO = 3, DN = 2, CAP = 3, CW = 2;

    logic       clk = 0, reset_n = 0;
    logic       car_entered = 0, sensor_exit_in = 0, sensor_exit_out = 0, ticket_valid = 0;
    logic [3:0] ticket_code = 0;
    logic       attendant_open = 0;
    logic       ticket_ready, gate_open, GREEN_LED, RED_LED, lot_full, lot_empty, err_underflow;
    logic [CW-1:0] occupancy;

    int checks = 0, errors = 0;
    bit cmp_en = 0;

    parking_exit_gate #(
        .TICK_DIV(DIV), .TIMEOUT_TICKS(TO), .DENY_TICKS(DN), .CAPACITY(CAP), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .car_entered(car_entered),
        .sensor_exit_in(sensor_exit_in), .sensor_exit_out(sensor_exit_out),
        .ticket_valid(ticket_valid), .ticket_code(ticket_code),
`ifdef PARKING_EXIT_OVERRIDE_EN
        .attendant_open(attendant_open),
`endif
        .ticket_ready(ticket_ready), .gate_open(gate_open), .GREEN_LED(GREEN_LED),
        .RED_LED(RED_LED), .occupancy(occupancy), .lot_full(lot_full),
        .lot_empty(lot_empty), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle,1 wait,2 check,3 open,4 passing,5 deny; time measured in clk cycles since mode entry.
    int   m_mode = 0, m_cyc = 0, m_occ = 0;
    bit   m_err = 0;
    logic [3:0] m_code = 0;

    function automatic int next_mode();
        int nm = m_mode;
        case (m_mode)
            0: if (sensor_exit_in) nm = 1;
            1: if (ticket_valid) nm = 2;
               else if (m_cyc == TO * DIV - 1) nm = 5;
               else if (!sensor_exit_in) nm = 0;
            2: nm = (m_code == 4'b1001) ? 3 : 5;
            3: if (sensor_exit_out) nm = 4;
            4: if (!sensor_exit_out) nm = 0;
            5: if (m_cyc == DN * DIV - 1) nm = 0;
            default: nm = 0;
        endcase
`ifdef PARKING_EXIT_OVERRIDE_EN
        if (attendant_open && (m_mode == 1 || m_mode == 5)) nm = 3;
`endif
        return nm;
    endfunction

    function automatic int next_occ();
        bit leaving = (m_mode == 4) && !sensor_exit_out;
        if (car_entered && !leaving) return (m_occ < CAP) ? m_occ + 1 : m_occ;
        if (leaving && !car_entered) return (m_occ > 0) ? m_occ - 1 : 0;
        return m_occ;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= 0; m_cyc <= 0; m_occ <= 0; m_err <= 0; m_code <= 0;
        end else begin
            m_mode <= next_mode();
            m_cyc  <= (next_mode() != m_mode) ? 0 : m_cyc + 1;
            m_occ  <= next_occ();
            if (m_mode == 4 && !sensor_exit_out && !car_entered && m_occ == 0) m_err <= 1;
            if (m_mode == 1 && ticket_valid) m_code <= ticket_code;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) if (cmp_en) begin
        chk("ready", 32'(ticket_ready), 32'(m_mode == 1));
        chk("gate",  32'(gate_open),    32'(m_mode == 3 || m_mode == 4));
        chk("green", 32'(GREEN_LED),    32'(m_mode == 3 || m_mode == 4));
        chk("red",   32'(RED_LED),      32'(m_mode == 1 || (m_mode == 5 && (m_cyc / DIV) % 2 == 0)));
        chk("occ",   32'(occupancy),    32'(m_occ));
        chk("full",  32'(lot_full),     32'(m_occ == CAP));
        chk("empty", 32'(lot_empty),    32'(m_occ == 0));
        chk("err",   32'(err_underflow),32'(m_err));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_car();
        car_entered = 1; step(1);
        car_entered = 0; step(1);
    endtask

    // Drives up to the cycle after CHECK (OPEN or DENY).
    task automatic present(input logic [3:0] code);
        sensor_exit_in = 1; step(1);
        ticket_valid = 1; ticket_code = code; step(1);
        ticket_valid = 0; sensor_exit_in = 0; step(1);
    endtask

    task automatic drive_through();
        sensor_exit_out = 1; step(1);
        sensor_exit_out = 0; step(1);
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 0;
        step(2); reset_n = 1;
    endtask

    initial begin
        step(2);
        reset_n = 1;
        cmp_en  = 1;
        chk("rst_empty", 32'(lot_empty), 1);
        chk("rst_occ",   32'(occupancy), 0);
        chk("rst_gate",  32'(gate_open), 0);

        // Valid exit
        pulse_car(); pulse_car();
        chk("two_in", 32'(occupancy), 2);
        present(4'b1001);
        chk("open_lat", 32'(gate_open), 1);
        drive_through();
        chk("exit_gate", 32'(gate_open), 0);
        chk("exit_occ",  32'(occupancy), 1);

        // Wrong code
        present(4'b0110);
        chk("deny_red",  32'(RED_LED), 1);
        chk("deny_gate", 32'(gate_open), 0);
        step(DN * DIV);
        chk("deny_done_red", 32'(RED_LED), 0);
        chk("deny_occ", 32'(occupancy), 1);

        // Timeout
        sensor_exit_in = 1; step(1);
        chk("to_ready", 32'(ticket_ready), 1);
        step(TO * DIV);
        chk("to_ready_drop", 32'(ticket_ready), 0);
        chk("to_red", 32'(RED_LED), 1);
        sensor_exit_in = 0; step(DN * DIV);

        // Saturation and simultaneous in/out
        repeat (4) pulse_car();
        chk("sat_occ",  32'(occupancy), 3);
        chk("sat_full", 32'(lot_full), 1);
        present(4'b1001);
        sensor_exit_out = 1; step(1);
        sensor_exit_out = 0; car_entered = 1; step(1);
        car_entered = 0;
        chk("simul_occ", 32'(occupancy), 3);

        // Underflow
        do_reset();
        present(4'b1001);
        drive_through();
        chk("uf_occ", 32'(occupancy), 0);
        chk("uf_err", 32'(err_underflow), 1);
        step(3);
        chk("uf_sticky", 32'(err_underflow), 1);

        // Reset in PASSING
        pulse_car();
        present(4'b1001);
        sensor_exit_out = 1; step(1);
        chk("pass_gate", 32'(gate_open), 1);
        #2 reset_n = 0;
        #1;
        chk("arst_gate",  32'(gate_open), 0);
        chk("arst_occ",   32'(occupancy), 0);
        chk("arst_ready", 32'(ticket_ready), 0);
        chk("arst_err",   32'(err_underflow), 0);
        @(negedge clk); reset_n = 1; sensor_exit_out = 0;
        step(2);

`ifdef PARKING_EXIT_OVERRIDE_EN
        pulse_car();
        present(4'b0110);
        chk("ovr_deny", 32'(gate_open), 0);
        attendant_open = 1; step(1);
        attendant_open = 0;
        chk("ovr_open", 32'(gate_open), 1);
        drive_through();
        chk("ovr_occ", 32'(occupancy), 0);
`endif
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
